// File: rtl/ofdm_pkg.sv
// Shared types and framer timing constants for the OFDM framer and its sequencing controller.
package ofdm_pkg;

    typedef enum logic [1:0] {
        S_ARMED,
        S_WAIT_HDR,
        S_RUN,
        S_HOLDOFF
    } ctrl_state_t;

    // Width needed to hold a symbol count from 0 up to max_num_symbols inclusive.
    function automatic int nsym_w(input int max_num_symbols);
        return $clog2(max_num_symbols + 1);
    endfunction

    localparam int MAX_NUM_SYMBOLS           = 256;
    localparam int NSYM_W                    = nsym_w(MAX_NUM_SYMBOLS);

    localparam int SYMBOL_LEN                = 64;
    localparam int CYCLIC_PREFIX_LEN         = 16;
    localparam int LONG_PREAMBLE_NUM_SYMBOLS = 2;

endpackage

// File: rtl/ofdm_symbol_counter.sv
// Counts framer output symbols since frame start and derives the number of data symbols completed.
module ofdm_symbol_counter
    import ofdm_pkg::*;
#(
    parameter int NSYM_W       = ofdm_pkg::NSYM_W,
    parameter int PREAMBLE_SYM = ofdm_pkg::LONG_PREAMBLE_NUM_SYMBOLS
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              sym_beat,
    output logic [NSYM_W+1:0] sym_cnt,
    output logic [NSYM_W+1:0] data_done
);

    localparam int              CW      = NSYM_W + 2;
    localparam logic [CW-1:0]   CNT_MAX = '1;
    localparam logic [CW-1:0]   PRE     = CW'(PREAMBLE_SYM);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sym_cnt <= '0;
        end else if (clear) begin
            sym_cnt <= '0;
        end else if (sym_beat && (sym_cnt != CNT_MAX)) begin
            sym_cnt <= sym_cnt + CW'(1);
        end
    end

    // Preamble symbols are not data symbols; floor at zero while they are still going out.
    assign data_done = (sym_cnt >= PRE) ? (sym_cnt - PRE) : '0;

endmodule

// File: rtl/ofdm_framer_ctrl.sv
// Sequencing controller for the OFDM framer: gates triggers, turns header results into
// num_symbols, aborts on missing/bad headers and enforces a holdoff gap between frames.
module ofdm_framer_ctrl
    import ofdm_pkg::*;
#(
    parameter int LONG_PREAMBLE_NUM_SYMBOLS = ofdm_pkg::LONG_PREAMBLE_NUM_SYMBOLS,
    parameter int HDR_SYMBOLS               = 1,
    parameter int HDR_TIMEOUT_SYMBOLS       = 4,
    parameter int MAX_NUM_SYMBOLS           = ofdm_pkg::MAX_NUM_SYMBOLS,
    parameter int HOLDOFF_CYCLES            = 32,
    parameter int NSYM_W                    = nsym_w(MAX_NUM_SYMBOLS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              det_tlast,
    input  logic              det_beat,
    output logic              trig_tlast,
    input  logic              fr_beat,
    input  logic              fr_tlast,
    input  logic              fr_eof,
    input  logic [NSYM_W-1:0] hdr_num_symbols,
    input  logic              hdr_valid,
    input  logic              hdr_error,
    output logic [NSYM_W-1:0] num_symbols,
    output logic              num_symbols_valid,
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       abort_cnt
);

    localparam int                CW      = NSYM_W + 2;
    localparam int                HO_W    = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HO_W-1:0]   HO_LAST = HO_W'((HOLDOFF_CYCLES > 1) ? HOLDOFF_CYCLES - 1 : 0);
    localparam logic [CW-1:0]     TIMEOUT = CW'(HDR_TIMEOUT_SYMBOLS);
    localparam logic [NSYM_W:0]   MAX_EXT = (NSYM_W+1)'(MAX_NUM_SYMBOLS);

    logic [1:0]        rst_sync;
    logic              rst_n;
    ctrl_state_t       state;
    logic [HO_W-1:0]   cnt;
    logic              abort_flag;
    logic              sym_beat;
    logic              end_beat;
    logic              frame_start;
    logic              timeout;
    logic [CW-1:0]     sym_cnt;
    logic [CW-1:0]     data_done;
    logic [NSYM_W:0]   hdr_sum;
    logic [NSYM_W-1:0] hdr_clamped;

    // Assert asynchronously, release on a clock edge so no flop sees reset removal mid-setup.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n = rst_sync[1];

    assign sym_beat    = fr_beat & fr_tlast;
    assign end_beat    = sym_beat & fr_eof;
    assign trig_tlast  = det_tlast & enable & (state == S_ARMED);
    assign frame_start = trig_tlast & det_beat;
    assign busy        = (state != S_ARMED);
    assign timeout     = (data_done >= TIMEOUT);

    ofdm_symbol_counter #(
        .NSYM_W       (NSYM_W),
        .PREAMBLE_SYM (LONG_PREAMBLE_NUM_SYMBOLS)
    ) u_sym_cnt (
        .clk       (clk),
        .reset_n   (rst_n),
        .clear     (frame_start),
        .sym_beat  (sym_beat),
        .sym_cnt   (sym_cnt),
        .data_done (data_done)
    );

    // Header count plus the SIGNAL symbol, widened by one bit so a large header cannot wrap before the clamp.
    // NOTE: combinational outputs get a default on every path so no latch is inferred.
    always_comb begin
        hdr_sum     = {1'b0, hdr_num_symbols} + (NSYM_W+1)'(HDR_SYMBOLS);
        hdr_clamped = hdr_sum[NSYM_W-1:0];
        if (hdr_sum > MAX_EXT) begin
            hdr_clamped = NSYM_W'(MAX_NUM_SYMBOLS);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_HOLDOFF;
            cnt               <= '0;
            abort_flag        <= 1'b0;
            num_symbols       <= '0;
            num_symbols_valid <= 1'b0;
            frame_cnt         <= '0;
            abort_cnt         <= '0;
        end else begin
            case (state)
                S_ARMED: begin
                    if (frame_start) begin
                        abort_flag <= 1'b0;
                        state      <= S_WAIT_HDR;
                    end
                end

                S_WAIT_HDR: begin
                    if (end_beat) begin
                        // Framer ran to its own limit before any header result arrived.
                        abort_cnt <= abort_cnt + 16'd1;
                        cnt       <= '0;
                        state     <= S_HOLDOFF;
                    end else if (hdr_valid && !hdr_error) begin
                        num_symbols       <= hdr_clamped;
                        num_symbols_valid <= 1'b1;
                        state             <= S_RUN;
                    end else if (hdr_valid || timeout) begin
                        // One symbol makes the framer close out after the symbol in flight.
                        num_symbols       <= NSYM_W'(1);
                        num_symbols_valid <= 1'b1;
                        abort_flag        <= 1'b1;
                        state             <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (end_beat) begin
                        if (abort_flag) begin
                            abort_cnt <= abort_cnt + 16'd1;
                        end else begin
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                        num_symbols_valid <= 1'b0;
                        cnt               <= '0;
                        state             <= S_HOLDOFF;
                    end
                end

                S_HOLDOFF: begin
                    cnt <= cnt + HO_W'(1);
                    if (cnt == HO_LAST) begin
                        state <= S_ARMED;
                    end
                end

                default: begin
                    cnt   <= '0;
                    state <= S_HOLDOFF;
                end
            endcase
        end
    end

endmodule
